// File: rtl/instr_enc_pkg.sv
// Shared definitions for the RV32I instruction encoder: request classes,
// base opcodes, the field packer and the immediate range checker. The
// packer is also used by stimulus generators that build program images.
package instr_enc_pkg;

  typedef enum logic [3:0] {
    CLS_R      = 4'd0,
    CLS_I_ALU  = 4'd1,
    CLS_LOAD   = 4'd2,
    CLS_JALR   = 4'd3,
    CLS_STORE  = 4'd4,
    CLS_BRANCH = 4'd5,
    CLS_JAL    = 4'd6,
    CLS_LUI    = 4'd7,
    CLS_AUIPC  = 4'd8
  } instr_class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Class codes above AUIPC are not defined and must never be encoded.
  function automatic logic class_defined(input logic [3:0] cls);
    return (cls <= 4'd8);
  endfunction

  // Shift-immediates (SLLI/SRLI/SRAI) use a 5-bit shamt instead of imm[11:0].
  function automatic logic is_shift_imm(input logic [3:0] cls, input logic [2:0] funct3);
    return (cls == CLS_I_ALU) && ((funct3 == 3'd1) || (funct3 == 3'd5));
  endfunction

  // Pack request fields into a 32-bit RV32I word. Fields a class does not
  // use stay zero; immediates are truncated to the bits the format carries.
  function automatic logic [31:0] pack_instr(
    input logic [3:0]  cls,
    input logic [2:0]  funct3,
    input logic        funct7b,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    logic [31:0] w;
    w = 32'h0000_0000;
    case (cls)
      CLS_R:      w = {1'b0, funct7b, 5'b00000, rs2, rs1, funct3, rd, OP_R};
      CLS_I_ALU: begin
        if (is_shift_imm(cls, funct3)) begin
          w = {1'b0, funct7b, 5'b00000, imm[4:0], rs1, funct3, rd, OP_IMM};
        end else begin
          w = {imm[11:0], rs1, funct3, rd, OP_IMM};
        end
      end
      CLS_LOAD:   w = {imm[11:0], rs1, funct3, rd, OP_LOAD};
      CLS_JALR:   w = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
      CLS_STORE:  w = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
      CLS_BRANCH: w = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
      CLS_JAL:    w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      CLS_LUI:    w = {imm[31:12], rd, OP_LUI};
      CLS_AUIPC:  w = {imm[31:12], rd, OP_AUIPC};
      default:    w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  // True when the immediate fits the target field without loss.
  function automatic logic imm_in_range(
    input logic [3:0]  cls,
    input logic [2:0]  funct3,
    input logic [31:0] imm
  );
    logic signed [31:0] s;
    logic ok;
    s  = $signed(imm);
    ok = 1'b1;
    case (cls)
      CLS_I_ALU: begin
        if (is_shift_imm(cls, funct3)) begin
          ok = (s >= 32'sd0) && (s <= 32'sd31);
        end else begin
          ok = (s >= -32'sd2048) && (s <= 32'sd2047);
        end
      end
      CLS_LOAD, CLS_JALR, CLS_STORE: ok = (s >= -32'sd2048) && (s <= 32'sd2047);
      CLS_BRANCH: ok = (s >= -32'sd4096) && (s <= 32'sd4094) && (imm[0] == 1'b0);
      CLS_JAL:    ok = (s >= -32'sd1048576) && (s <= 32'sd1048574) && (imm[0] == 1'b0);
      CLS_LUI, CLS_AUIPC: ok = (imm[11:0] == 12'h000);
      default:    ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Synchronous FIFO holding encoded words between the encoder and the
// instruction-memory load port. DEPTH must be a power of two so the
// pointers wrap naturally. The head word is presented combinationally.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage array; cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Write/read pointers advance on their own accepted operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
    end
  end

  // Occupancy: simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: accepts field-level requests, packs them into
// 32-bit words, buffers them and emits address/data beats to the
// instruction-memory load port.
// Optional build macro INSTR_ENCODER_RANGE_CHECK_EN: reject requests whose
// immediate does not fit the target field (accepted, dropped, err_pulse).
// Without it, immediates are silently truncated and only undefined classes
// raise an error.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int                    DEPTH      = 4,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_class,
  input  logic [2:0]            req_funct3,
  input  logic                  req_funct7b,
  input  logic [4:0]            req_rd,
  input  logic [4:0]            req_rs1,
  input  logic [4:0]            req_rs2,
  input  logic [31:0]           req_imm,
  input  logic                  addr_load,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [31:0]           out_instr,
  output logic                  err_pulse,
  output logic                  err_sticky
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]           enc_word_s;
  logic                  enc_ok_s;
  logic                  accept_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  bad_req_s;
  logic                  full_s;
  logic                  empty_s;
  logic [CNT_W-1:0]      fifo_count_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  err_pulse_r;
  logic                  err_sticky_r;

  assign enc_word_s = pack_instr(req_class, req_funct3, req_funct7b,
                                 req_rd, req_rs1, req_rs2, req_imm);

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  assign enc_ok_s = class_defined(req_class) &&
                    imm_in_range(req_class, req_funct3, req_imm);
`else
  assign enc_ok_s = class_defined(req_class);
`endif

  // Ready depends only on FIFO state, never on the sink, so a full FIFO
  // cannot accept even when a pop happens in the same cycle.
  assign req_ready = !full_s;
  assign accept_s  = req_valid && !full_s;
  // The occupancy term is redundant with !full_s; it keeps a push from
  // ever being issued into a full FIFO should the ready logic change.
  assign push_s    = accept_s && enc_ok_s && (fifo_count_s < CNT_W'(DEPTH));
  assign bad_req_s = accept_s && !enc_ok_s;
  assign pop_s     = !empty_s && out_ready;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (enc_word_s),
    .rdata (out_instr),
    .full  (full_s),
    .empty (empty_s),
    .count (fifo_count_s)
  );

  assign out_valid  = !empty_s;
  assign out_addr   = addr_r;
  assign err_pulse  = err_pulse_r;
  assign err_sticky = err_sticky_r;

  // Write-address counter: an explicit load wins over the post-pop step;
  // the beat popped in that cycle has already used the old address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= BASE_ADDR;
    end else if (addr_load) begin
      addr_r <= addr_in;
    end else if (pop_s) begin
      addr_r <= addr_r + ADDR_WIDTH'(32'd4);
    end else begin
      addr_r <= addr_r;
    end
  end

  // Dropped-request reporting: one-cycle pulse plus a flag held until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse_r  <= 1'b0;
      err_sticky_r <= 1'b0;
    end else begin
      err_pulse_r  <= bad_req_s;
      err_sticky_r <= err_sticky_r | bad_req_s;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a table of encodings with hand-computed
// words, followed by hand-written multi-cycle sequences for backpressure,
// back-to-back streaming, address load/wrap, error reporting and reset.
`timescale 1ns/1ps
module tb_instr_encoder;
  import instr_enc_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_class;
  logic [2:0]    req_funct3;
  logic          req_funct7b;
  logic [4:0]    req_rd;
  logic [4:0]    req_rs1;
  logic [4:0]    req_rs2;
  logic [31:0]   req_imm;
  logic          addr_load;
  logic [AW-1:0] addr_in;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [31:0]   out_instr;
  logic          err_pulse;
  logic          err_sticky;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_class(req_class),
    .req_funct3(req_funct3), .req_funct7b(req_funct7b), .req_rd(req_rd),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .addr_load(addr_load), .addr_in(addr_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_instr(out_instr), .err_pulse(err_pulse), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic        f7b;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[14];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [2:0] f3, input logic f7b,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
    req_class = c; req_funct3 = f3; req_funct7b = f7b;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    req_valid = 1'b1;
  endtask

  // ADDI rd, x0, imm written out by hand: {imm[11:0], 5'd0, 3'd0, rd, 0010011}
  function automatic logic [31:0] addi_word(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd0, 3'd0, rd, 7'b0010011};
  endfunction

  // Push one table entry with the sink stalled, check the beat, then pop it.
  task automatic run_vec(input int i);
    @(negedge clk);
    out_ready = 1'b0;
    drive(vecs[i].cls, vecs[i].f3, vecs[i].f7b, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
    @(negedge clk);
    req_valid = 1'b0;
    check({vecs[i].name, "_valid"}, {31'd0, out_valid}, 32'd1);
    check(vecs[i].name, out_instr, vecs[i].exp);
    check({vecs[i].name, "_addr"}, out_addr, exp_addr);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_addr = exp_addr + 32'd4;
    check({vecs[i].name, "_empty"}, {31'd0, out_valid}, 32'd0);
    check({vecs[i].name, "_next_addr"}, out_addr, exp_addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{"addi",   CLS_I_ALU,  3'd0, 1'b0, 5'd1,  5'd0, 5'd0,  32'd5,        32'h00500093};
    vecs[1]  = '{"sub",    CLS_R,      3'd0, 1'b1, 5'd3,  5'd1, 5'd2,  32'h12345678, 32'h402081B3};
    vecs[2]  = '{"sw",     CLS_STORE,  3'd2, 1'b0, 5'd9,  5'd1, 5'd2,  32'd8,        32'h0020A423};
    vecs[3]  = '{"beq",    CLS_BRANCH, 3'd0, 1'b0, 5'd0,  5'd1, 5'd2,  32'hFFFFFFFC, 32'hFE208EE3};
    vecs[4]  = '{"jal",    CLS_JAL,    3'd7, 1'b0, 5'd1,  5'd3, 5'd0,  32'd2048,     32'h001000EF};
    vecs[5]  = '{"lui",    CLS_LUI,    3'd0, 1'b0, 5'd5,  5'd31, 5'd31, 32'h12345000, 32'h123452B7};
    vecs[6]  = '{"srai",   CLS_I_ALU,  3'd5, 1'b1, 5'd2,  5'd3, 5'd0,  32'd7,        32'h4071D113};
    vecs[7]  = '{"lw",     CLS_LOAD,   3'd2, 1'b0, 5'd4,  5'd2, 5'd0,  32'hFFFFFFF8, 32'hFF812203};
    vecs[8]  = '{"jalr",   CLS_JALR,   3'd3, 1'b1, 5'd1,  5'd5, 5'd7,  32'd16,       32'h010280E7};
    vecs[9]  = '{"auipc",  CLS_AUIPC,  3'd0, 1'b0, 5'd10, 5'd0, 5'd0,  32'hFFFFF000, 32'hFFFFF517};
    vecs[10] = '{"slli31", CLS_I_ALU,  3'd1, 1'b0, 5'd6,  5'd6, 5'd0,  32'd31,       32'h01F31313};
    vecs[11] = '{"bne_max",CLS_BRANCH, 3'd1, 1'b0, 5'd0,  5'd3, 5'd4,  32'd4094,     32'h7E419FE3};
    vecs[12] = '{"jal_min",CLS_JAL,    3'd0, 1'b0, 5'd0,  5'd0, 5'd0,  32'hFFF00000, 32'h8000006F};
    vecs[13] = '{"xori_min",CLS_I_ALU, 3'd4, 1'b0, 5'd7,  5'd8, 5'd0,  32'hFFFFF800, 32'h80044393};

    rst_n = 1'b0; req_valid = 1'b0; req_class = 4'd0; req_funct3 = 3'd0;
    req_funct7b = 1'b0; req_rd = 5'd0; req_rs1 = 5'd0; req_rs2 = 5'd0;
    req_imm = 32'd0; addr_load = 1'b0; addr_in = 32'd0; out_ready = 1'b0;
    exp_addr = 32'h0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_addr", out_addr, 32'h0);
    check("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
    check("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
    rst_n = 1'b1;

    // Encoding table
    for (int i = 0; i < 14; i++) begin
      run_vec(i);
    end

    // Backpressure: DEPTH+1 requests against a stalled sink
    for (int i = 0; i <= DEPTH; i++) begin
      @(negedge clk);
      check("bp_ready", {31'd0, req_ready}, (i < DEPTH) ? 32'd1 : 32'd0);
      if (i > 0) check("bp_hold_head", out_instr, addi_word(5'd1, 12'd1));
      drive(CLS_I_ALU, 3'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, 32'(i + 1));
    end
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_full_ready", {31'd0, req_ready}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("bp_stable_instr", out_instr, addi_word(5'd1, 12'd1));
      check("bp_stable_addr", out_addr, exp_addr);
    end
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("bp_drain_instr", out_instr, addi_word(5'(i + 1), 12'(i + 1)));
      check("bp_drain_addr", out_addr, exp_addr);
      @(negedge clk);
      exp_addr = exp_addr + 32'd4;
    end
    check("bp_drained", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Back-to-back stream: push and pop in the same cycle
    @(negedge clk);
    out_ready = 1'b1;
    drive(CLS_I_ALU, 3'd0, 1'b0, 5'd9, 5'd0, 5'd0, 32'd100);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("stream_valid", {31'd0, out_valid}, 32'd1);
      check("stream_instr", out_instr, addi_word(5'd9, 12'(99 + i)));
      check("stream_addr", out_addr, exp_addr);
      exp_addr = exp_addr + 32'd4;
      if (i < 3) drive(CLS_I_ALU, 3'd0, 1'b0, 5'd9, 5'd0, 5'd0, 32'(100 + i));
      else req_valid = 1'b0;
    end
    @(negedge clk);
    check("stream_end", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // addr_load on a pop cycle
    @(negedge clk);
    drive(CLS_I_ALU, 3'd0, 1'b0, 5'd11, 5'd0, 5'd0, 32'd1);
    @(negedge clk);
    drive(CLS_I_ALU, 3'd0, 1'b0, 5'd12, 5'd0, 5'd0, 32'd2);
    @(negedge clk);
    req_valid = 1'b0;
    check("ld_old_addr", out_addr, exp_addr);
    check("ld_first", out_instr, addi_word(5'd11, 12'd1));
    out_ready = 1'b1; addr_load = 1'b1; addr_in = 32'h100;
    @(negedge clk);
    out_ready = 1'b0; addr_load = 1'b0;
    check("ld_new_addr", out_addr, 32'h100);
    check("ld_second", out_instr, addi_word(5'd12, 12'd2));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("ld_after_pop", out_addr, 32'h104);

    // Address wrap at the top of the space
    addr_load = 1'b1; addr_in = 32'hFFFFFFFC;
    drive(CLS_I_ALU, 3'd0, 1'b0, 5'd13, 5'd0, 5'd0, 32'd3);
    @(negedge clk);
    addr_load = 1'b0; req_valid = 1'b0;
    check("wrap_top", out_addr, 32'hFFFFFFFC);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("wrap_zero", out_addr, 32'h0);
    exp_addr = 32'h0;

    // Out-of-range STORE immediate
    drive(CLS_STORE, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4096);
    @(negedge clk);
    req_valid = 1'b0;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    check("rng_pulse", {31'd0, err_pulse}, 32'd1);
    check("rng_sticky", {31'd0, err_sticky}, 32'd1);
    check("rng_not_pushed", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("rng_pulse_end", {31'd0, err_pulse}, 32'd0);
    check("rng_still_empty", {31'd0, out_valid}, 32'd0);
`else
    check("trunc_pulse", {31'd0, err_pulse}, 32'd0);
    check("trunc_sticky", {31'd0, err_sticky}, 32'd0);
    check("trunc_valid", {31'd0, out_valid}, 32'd1);
    check("trunc_instr", out_instr, 32'h0020A023);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_addr = exp_addr + 32'd4;
`endif

    // Undefined class: accepted, dropped, error pulse
    drive(4'hB, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    check("undef_pulse", {31'd0, err_pulse}, 32'd1);
    check("undef_sticky", {31'd0, err_sticky}, 32'd1);
    check("undef_not_pushed", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("undef_pulse_end", {31'd0, err_pulse}, 32'd0);
    check("undef_sticky_hold", {31'd0, err_sticky}, 32'd1);

    // Asynchronous reset mid-stream
    drive(CLS_I_ALU, 3'd0, 1'b0, 5'd14, 5'd0, 5'd0, 32'd4);
    @(negedge clk);
    drive(CLS_I_ALU, 3'd0, 1'b0, 5'd15, 5'd0, 5'd0, 32'd5);
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_instr", out_instr, 32'h0);
    check("mid_rst_addr", out_addr, 32'h0);
    check("mid_rst_sticky", {31'd0, err_sticky}, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    exp_addr = 32'h0;
    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
